// File: rtl/arbitro_escritura_banco.sv
// Round-robin arbiter for the single write port of banco_registro, with a clear sequencer.
// Optional build macro REG0_PROTECT_EN: requester writes to address 0 are acked but suppressed.
module arbitro_escritura_banco #(
    parameter int unsigned N = 6,
    parameter int unsigned W = 6,
    parameter int unsigned R = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [R-1:0]   req,
    input  logic [R*N-1:0] addr_req,
    input  logic [R*W-1:0] data_req,
    output logic [R-1:0]   ack,
    input  logic           clr_start,
    output logic           busy,
    output logic           clr_done,
    output logic           we,
    output logic [N-1:0]   addr_rd,
    output logic [W-1:0]   data_in
);

    localparam int unsigned PW = (R > 1) ? $clog2(R) : 1;

    typedef enum logic [1:0] {StIdle, StClear, StDone} state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]  ptr_q, ptr_d;

    logic [R-1:0]   ack_q, ack_d;
    logic           we_q, we_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [N-1:0]   addr_q, addr_d;
    logic [W-1:0]   data_q, data_d;

    logic [R-1:0]   elig;
    logic           grant_valid;
    logic [PW-1:0]  grant_idx;
    logic [PW-1:0]  ptr_next;
    logic [N-1:0]   grant_addr;
    logic [W-1:0]   grant_data;
    logic           arb_en;
    int unsigned    idx;

    // The requester acked this cycle still holds req, so it is masked out.
    always_comb begin
        elig        = req & ~ack_q;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int unsigned i = 0; i < R; i++) begin
            idx = (32'(ptr_q) + i) % R;
            if (!grant_valid && elig[idx[PW-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = idx[PW-1:0];
            end
        end
        ptr_next   = (grant_idx == PW'(R - 1)) ? '0 : grant_idx + PW'(1);
        grant_addr = addr_req[grant_idx*N +: N];
        grant_data = data_req[grant_idx*W +: W];
    end

    assign arb_en = ((state_q == StIdle) && !clr_start) || (state_q == StDone);

    // State register (all outputs are registered alongside it).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ptr_q   <= '0;
            ack_q   <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            ack_q   <= ack_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Next-state logic; cnt_q is the address currently on the port during StClear.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (clr_start) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            StClear: begin
                if (cnt_q == '1) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + N'(1);
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (arb_en && grant_valid) begin
            ptr_d = ptr_next;
        end
    end

    // Output logic: values presented on the port in the next cycle.
    always_comb begin
        ack_d  = '0;
        we_d   = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        addr_d = '0;
        data_d = '0;
        unique case (state_q)
            StIdle: begin
                if (clr_start) begin
                    we_d   = 1'b1;
                    busy_d = 1'b1;
                end
            end
            StClear: begin
                if (cnt_q == '1) begin
                    done_d = 1'b1;
                end else begin
                    we_d   = 1'b1;
                    busy_d = 1'b1;
                    addr_d = cnt_q + N'(1);
                end
            end
            default: ;
        endcase
        if (arb_en && grant_valid) begin
            ack_d[grant_idx] = 1'b1;
            addr_d           = grant_addr;
            data_d           = grant_data;
`ifdef REG0_PROTECT_EN
            we_d             = (grant_addr != '0);
`else
            we_d             = 1'b1;
`endif
        end
    end

    assign ack      = ack_q;
    assign we       = we_q;
    assign busy     = busy_q;
    assign clr_done = done_q;
    assign addr_rd  = addr_q;
    assign data_in  = data_q;

endmodule

// File: tb/tb_arbitro_escritura_banco.sv
// Directed bench for arbitro_escritura_banco with a behavioural register bank on the write port.
module tb_arbitro_escritura_banco;

    localparam int N = 6;
    localparam int W = 6;
    localparam int R = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [R-1:0]   req;
    logic [R*N-1:0] addr_req;
    logic [R*W-1:0] data_req;
    logic [R-1:0]   ack;
    logic           clr_start;
    logic           busy;
    logic           clr_done;
    logic           we;
    logic [N-1:0]   addr_rd;
    logic [W-1:0]   data_in;

    logic [W-1:0]   bank [64];
    logic [W-1:0]   prior [64];

    int n_tests = 0;
    int n_fail  = 0;

    arbitro_escritura_banco #(.N(N), .W(W), .R(R)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .addr_req (addr_req),
        .data_req (data_req),
        .ack      (ack),
        .clr_start(clr_start),
        .busy     (busy),
        .clr_done (clr_done),
        .we       (we),
        .addr_rd  (addr_rd),
        .data_in  (data_in)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (we) bank[addr_rd] <= data_in;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [N-1:0] a, input logic [W-1:0] d);
        addr_req[k*N +: N] = a;
        data_req[k*W +: W] = d;
    endtask

    // Packed status: {busy, clr_done, we, ack}
    function automatic logic [31:0] status();
        return {25'd0, busy, clr_done, we, ack};
    endfunction

    initial begin
        int bad;
        logic seen_done;
        rst = 1'b1; req = '0; addr_req = '0; data_req = '0; clr_start = 1'b0;
        tick();
        tick();
        check("reset_status", status(), 32'h0);
        check("reset_addr", {26'd0, addr_rd}, 32'd0);
        check("reset_data", {26'd0, data_in}, 32'd0);
        rst = 1'b0;

        // 1. Single requester
        set_req(2, 6'd5, 6'h2A);
        req = 4'b0100;
        tick();
        check("single_status", status(), {25'd0, 3'b001, 4'b0100});
        check("single_addr", {26'd0, addr_rd}, 32'd5);
        check("single_data", {26'd0, data_in}, 32'h2A);
        req = '0;
        tick();
        check("single_idle", status(), 32'h0);
        check("single_bank", {26'd0, bank[5]}, 32'h2A);

        // 2. All four held from reset: strict rotation
        rst = 1'b1;
        req = 4'b1111;
        for (int k = 0; k < R; k++) set_req(k, 6'(10 + k), 6'(k + 1));
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("rr_ack%0d", i), {28'd0, ack}, 32'(1 << (i % 4)));
            check($sformatf("rr_addr%0d", i), {26'd0, addr_rd}, 32'(10 + i % 4));
        end
        req = '0;
        tick();
        check("rr_idle", status(), 32'h0);

        // 3. Clear with req[1] pending; clear wins; clr_start in CLEAR/DONE ignored
        set_req(1, 6'd7, 6'h15);
        req = 4'b0010;
        clr_start = 1'b1;
        tick();
        for (int c = 0; c < 64; c++) begin
            check($sformatf("clr_status%0d", c), status(), {25'd0, 3'b101, 4'b0000});
            check($sformatf("clr_addr%0d", c), {26'd0, addr_rd, data_in}, 32'(c << W));
            clr_start = (c == 10);
            tick();
        end
        check("clr_done", status(), {25'd0, 3'b010, 4'b0000});
        clr_start = 1'b1;
        tick();
        check("clr_after_ack", status(), {25'd0, 3'b001, 4'b0010});
        check("clr_after_addr", {26'd0, addr_rd}, 32'd7);
        clr_start = 1'b0;
        req = '0;
        tick();
        check("clr_after_idle", status(), 32'h0);
        bad = 0;
        for (int a = 0; a < 64; a++) begin
            if (bank[a] !== ((a == 7) ? 6'h15 : 6'h00)) bad++;
        end
        check("clr_bank", 32'(bad), 32'd0);

        // 4. Reset at clear count 20
        for (int a = 0; a < 64; a++) begin
            prior[a] = {1'b1, 5'(a)};
            set_req(0, 6'(a), prior[a]);
            req = 4'b0001;
            tick();
            req = '0;
            tick();
        end
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        repeat (20) tick();
        check("rstclr_addr20", {26'd0, addr_rd}, 32'd20);
        rst = 1'b1;
        #1;
        check("rstclr_status", status(), 32'h0);
        check("rstclr_addr", {26'd0, addr_rd}, 32'd0);
        tick();
        rst = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 70; i++) begin
            tick();
            seen_done = seen_done | clr_done | busy | we;
        end
        check("rstclr_quiet", {31'd0, seen_done}, 32'd0);
        bad = 0;
        for (int a = 0; a < 64; a++) begin
            if (bank[a] !== ((a < 20) ? 6'h00 : prior[a])) bad++;
        end
        check("rstclr_bank", 32'(bad), 32'd0);

        // Reset mid-grant: pointer returns to 0
        set_req(0, 6'd33, 6'h01);
        set_req(2, 6'd34, 6'h02);
        set_req(3, 6'd35, 6'h03);
        req = 4'b0001;
        tick();
        check("mg_ack0", {28'd0, ack}, 32'b0001);
        req = '0;
        tick();
        req = 4'b1100;
        tick();
        check("mg_ack2", {28'd0, ack}, 32'b0100);
        rst = 1'b1;
        #1;
        check("mg_dropped", status(), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check("mg_regrant", {28'd0, ack}, 32'b0100);
        req = 4'b1000;
        tick();
        check("mg_next", {28'd0, ack}, 32'b1000);
        req = '0;
        tick();

        // 5. Write to address 0
        set_req(0, 6'd0, 6'h3F);
        req = 4'b0001;
        tick();
        check("r0_ack", {28'd0, ack}, 32'b0001);
`ifdef REG0_PROTECT_EN
        check("r0_we", {31'd0, we}, 32'd0);
`else
        check("r0_we", {31'd0, we}, 32'd1);
`endif
        req = '0;
        tick();
`ifdef REG0_PROTECT_EN
        check("r0_bank", {26'd0, bank[0]}, 32'h00);
`else
        check("r0_bank", {26'd0, bank[0]}, 32'h3F);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
